// File: rtl/ethernet_fake_transmitter.sv
// Free-running Ethernet II / IPv4 / UDP frame source on a 64-bit AXI4-Stream master.
// No backpressure: each frame is a burst of back-to-back beats followed by a fixed idle gap.
module ethernet_fake_transmitter #(
   parameter logic [47:0] DST_MAC     = 48'h211abcdef112,
   parameter logic [47:0] SRC_MAC     = 48'h020000000001,
   parameter logic [31:0] DST_IP      = 32'hC0000186,
   parameter logic [31:0] SRC_IP      = 32'hC0000101,
   parameter logic [15:0] SRC_PORT    = 16'h04D2,
   parameter logic [15:0] DST_PORT    = 16'h1388,
   parameter int unsigned PAYLOAD_LEN = 18,
   parameter int unsigned GAP_CYCLES  = 12
) (
   input  logic        i_clk,
   input  logic        i_reset,
   output logic        o_tx_axis_tvalid,
   output logic [63:0] o_tx_axis_tdata,
   output logic        o_tx_axis_tlast,
   output logic [7:0]  o_tx_axis_tkeep
);

   localparam int unsigned HDR_LEN   = 42;
   localparam int unsigned FRAME_LEN = HDR_LEN + PAYLOAD_LEN;
   localparam int unsigned NUM_BEATS = (FRAME_LEN + 7) / 8;
   localparam logic [15:0] IP_LEN    = 16'(28 + PAYLOAD_LEN);
   localparam logic [15:0] UDP_LEN   = 16'(8 + PAYLOAD_LEN);
   localparam logic [7:0]  LAST_BEAT = 8'(NUM_BEATS - 1);
   localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

   // Sum of every IP header word except identification and checksum
   localparam logic [19:0] CSUM_FIXED = 20'h04500 + {4'h0, IP_LEN} + 20'h04000 + 20'h04011
                                      + {4'h0, SRC_IP[31:16]} + {4'h0, SRC_IP[15:0]}
                                      + {4'h0, DST_IP[31:16]} + {4'h0, DST_IP[15:0]};

   typedef enum logic {
      ST_GAP,
      ST_DATA
   } state_t;

   state_t       state, state_n;
   logic [15:0]  gap_cnt, gap_cnt_n;
   logic [7:0]   beat_idx, beat_idx_n;
   logic [15:0]  frame_cnt;
   logic [15:0]  ip_csum;
   logic [19:0]  csum_sum;
   logic [16:0]  csum_fold;
   logic [15:0]  csum_next;
   logic [335:0] hdr;
   logic [15:0]  byte_idx;
   logic [8:0]   hdr_off;
   logic [63:0]  beat_data;
   logic [7:0]   beat_keep;
   logic         beat_last;
   logic         tvalid_n;
   logic [63:0]  tdata_n;
   logic         tlast_n;
   logic [7:0]   tkeep_n;

   always_comb begin
      csum_sum  = CSUM_FIXED + {4'h0, frame_cnt};
      csum_fold = {1'b0, csum_sum[15:0]} + {13'h0, csum_sum[19:16]};
      csum_next = ~(csum_fold[15:0] + {15'h0, csum_fold[16]});
   end

   // Header packed with wire byte 0 in the most significant byte
   always_comb begin
      hdr = {DST_MAC, SRC_MAC, 16'h0800, 8'h45, 8'h00, IP_LEN, frame_cnt,
             16'h4000, 8'h40, 8'h11, ip_csum, SRC_IP, DST_IP,
             SRC_PORT, DST_PORT, UDP_LEN, 16'h0000};
   end

   always_comb begin
      beat_data = '0;
      beat_keep = '0;
      byte_idx  = '0;
      hdr_off   = '0;
      beat_last = (beat_idx == LAST_BEAT);
      for (int unsigned j = 0; j < 8; j++) begin
         byte_idx = {5'b0, beat_idx, 3'b0} + 16'(j);
         hdr_off  = 9'((HDR_LEN - 1 - 32'(byte_idx)) * 8);
         if (byte_idx < 16'(HDR_LEN)) begin
            beat_data[8*j +: 8] = hdr[hdr_off +: 8];
            beat_keep[j]        = 1'b1;
         end else if (byte_idx < 16'(FRAME_LEN)) begin
            beat_data[8*j +: 8] = frame_cnt[7:0] + 8'(byte_idx - 16'(HDR_LEN));
            beat_keep[j]        = 1'b1;
         end
      end
   end

   always_comb begin
      state_n    = state;
      gap_cnt_n  = gap_cnt;
      beat_idx_n = beat_idx;
      tvalid_n   = 1'b0;
      tdata_n    = '0;
      tlast_n    = 1'b0;
      tkeep_n    = '0;
      case (state)
         ST_GAP: begin
            if (gap_cnt == GAP_LAST) begin
               state_n   = ST_DATA;
               gap_cnt_n = '0;
            end else begin
               gap_cnt_n = gap_cnt + 16'd1;
            end
         end
         ST_DATA: begin
            tvalid_n = 1'b1;
            tdata_n  = beat_data;
            tkeep_n  = beat_keep;
            tlast_n  = beat_last;
            if (beat_last) begin
               state_n    = ST_GAP;
               beat_idx_n = '0;
            end else begin
               beat_idx_n = beat_idx + 8'd1;
            end
         end
         default: state_n = ST_GAP;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state            <= ST_GAP;
         gap_cnt          <= '0;
         beat_idx         <= '0;
         o_tx_axis_tvalid <= 1'b0;
         o_tx_axis_tdata  <= '0;
         o_tx_axis_tlast  <= 1'b0;
         o_tx_axis_tkeep  <= '0;
      end else begin
         state            <= state_n;
         gap_cnt          <= gap_cnt_n;
         beat_idx         <= beat_idx_n;
         o_tx_axis_tvalid <= tvalid_n;
         o_tx_axis_tdata  <= tdata_n;
         o_tx_axis_tlast  <= tlast_n;
         o_tx_axis_tkeep  <= tkeep_n;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         frame_cnt <= '0;
      end else if (state == ST_DATA && beat_last) begin
         frame_cnt <= frame_cnt + 16'd1;
      end
   end

   // Refreshed throughout the gap so it tracks the counter of the frame about to start
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         ip_csum <= '0;
      end else if (state == ST_GAP) begin
         ip_csum <= csum_next;
      end
   end

endmodule

// File: tb/tb_ethernet_fake_transmitter.sv
// Bench for ethernet_fake_transmitter: two instances (18- and 22-byte payloads) checked
// every cycle against a frame/period model built from the field layout.
module tb_ethernet_fake_transmitter;

   localparam logic [47:0] DST_MAC  = 48'h211abcdef112;
   localparam logic [47:0] SRC_MAC  = 48'h020000000001;
   localparam logic [31:0] DST_IP   = 32'hC0000186;
   localparam logic [31:0] SRC_IP   = 32'hC0000101;
   localparam logic [15:0] SRC_PORT = 16'h04D2;
   localparam logic [15:0] DST_PORT = 16'h1388;
   localparam int unsigned GAP      = 12;
   localparam int unsigned P_A      = 18;
   localparam int unsigned P_B      = 22;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a = 1'b1;
   logic        rst_b = 1'b1;
   logic        a_tvalid, b_tvalid;
   logic [63:0] a_tdata, b_tdata;
   logic        a_tlast, b_tlast;
   logic [7:0]  a_tkeep, b_tkeep;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned t_a = 0;
   int unsigned t_b = 0;
   logic [15:0] base_b = 16'h0000;

   ethernet_fake_transmitter u_dut_a (
      .i_clk            (clk),
      .i_reset          (rst_a),
      .o_tx_axis_tvalid (a_tvalid),
      .o_tx_axis_tdata  (a_tdata),
      .o_tx_axis_tlast  (a_tlast),
      .o_tx_axis_tkeep  (a_tkeep)
   );

   ethernet_fake_transmitter #(.PAYLOAD_LEN(P_B)) u_dut_b (
      .i_clk            (clk),
      .i_reset          (rst_b),
      .o_tx_axis_tvalid (b_tvalid),
      .o_tx_axis_tdata  (b_tdata),
      .o_tx_axis_tlast  (b_tlast),
      .o_tx_axis_tkeep  (b_tkeep)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] be16(input logic [63:0] d, input int unsigned j);
      return {d[8*j +: 8], d[8*j+8 +: 8]};
   endfunction

   function automatic logic [15:0] ip_word(input int unsigned p, input logic [15:0] id,
                                           input int unsigned w);
      case (w)
         0:       return 16'h4500;
         1:       return 16'(28 + p);
         2:       return id;
         3:       return 16'h4000;
         4:       return 16'h4011;
         6:       return 16'(SRC_IP >> 16);
         7:       return 16'(SRC_IP);
         8:       return 16'(DST_IP >> 16);
         9:       return 16'(DST_IP);
         default: return 16'h0000;
      endcase
   endfunction

   function automatic logic [15:0] ip_csum(input int unsigned p, input logic [15:0] id);
      int unsigned s = 0;
      for (int unsigned w = 0; w < 10; w++) s += 32'(ip_word(p, id, w));
      while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
      return ~16'(s);
   endfunction

   function automatic logic [7:0] frame_byte(input int unsigned p, input logic [15:0] id,
                                             input int unsigned idx);
      logic [15:0] w;
      if (idx < 6) return 8'(DST_MAC >> (8 * (5 - idx)));
      if (idx < 12) return 8'(SRC_MAC >> (8 * (11 - idx)));
      if (idx >= 42) return id[7:0] + 8'(idx - 42);
      if (idx < 14) w = 16'h0800;
      else if (idx < 34) w = ((idx - 14) / 2 == 5) ? ip_csum(p, id) : ip_word(p, id, (idx - 14) / 2);
      else if (idx < 36) w = SRC_PORT;
      else if (idx < 38) w = DST_PORT;
      else if (idx < 40) w = 16'(8 + p);
      else w = 16'h0000;
      return (idx % 2 == 0) ? w[15:8] : w[7:0];
   endfunction

   // t = rising edges since reset was last seen low (0 while in reset)
   task automatic model_out(input int unsigned p, input int unsigned t, input logic [15:0] base,
                            output logic v, output logic [63:0] d, output logic l,
                            output logic [7:0] k);
      int unsigned len, nb, per, u, ph, b, idx;
      logic [15:0] id;
      len = 42 + p;
      nb  = (len + 7) / 8;
      per = GAP + nb;
      v = 1'b0; d = '0; l = 1'b0; k = '0;
      if (t != 0) begin
         u  = t - 1;
         ph = u % per;
         if (ph >= GAP) begin
            b  = ph - GAP;
            id = base + 16'(u / per);
            v  = 1'b1;
            l  = (b == nb - 1);
            for (int unsigned j = 0; j < 8; j++) begin
               idx = 8 * b + j;
               if (idx < len) begin
                  d[8*j +: 8] = frame_byte(p, id, idx);
                  k[j] = 1'b1;
               end
            end
         end
      end
   endtask

   always @(posedge clk) begin : model_chk
      logic ra, rb, v, l;
      logic [63:0] d;
      logic [7:0] k;
      ra = rst_a;
      rb = rst_b;
      #1;
      t_a = ra ? 0 : t_a + 1;
      t_b = rb ? 0 : t_b + 1;
      model_out(P_A, t_a, 16'h0000, v, d, l, k);
      check("a_tvalid", 64'(a_tvalid), 64'(v));
      check("a_tdata", a_tdata, d);
      check("a_tlast", 64'(a_tlast), 64'(l));
      check("a_tkeep", 64'(a_tkeep), 64'(k));
      model_out(P_B, t_b, base_b, v, d, l, k);
      check("b_tvalid", 64'(b_tvalid), 64'(v));
      check("b_tdata", b_tdata, d);
      check("b_tlast", 64'(b_tlast), 64'(l));
      check("b_tkeep", 64'(b_tkeep), 64'(k));
   end

   function automatic logic cond(input int unsigned sel);
      case (sel)
         0:       return a_tvalid;
         1:       return a_tvalid & a_tlast;
         2:       return b_tvalid;
         default: return b_tvalid & b_tlast;
      endcase
   endfunction

   task automatic wait_until(input int unsigned sel, input string tag);
      int unsigned n = 0;
      do begin
         tick();
         n++;
      end while (!cond(sel) && n < 200);
      check(tag, 64'(cond(sel)), 64'h1);
   endtask

   task automatic first_beat_a(input string tag);
      int unsigned k = 0;
      do begin
         tick();
         k++;
      end while (!a_tvalid && k < 40);
      check(tag, 64'(k), 64'(GAP + 1));
   endtask

   task automatic drive_a();
      int unsigned k;
      repeat (3) tick();
      check("a_reset_valid", 64'(a_tvalid), 64'h0);
      check("a_reset_data", a_tdata, 64'h0);
      rst_a = 1'b0;
      first_beat_a("a_first_latency");
      check("a_b0_data", a_tdata, 64'h000212F1DEBC1A21);
      check("a_b0_keep", 64'(a_tkeep), 64'hFF);
      check("a_b0_last", 64'(a_tlast), 64'h0);
      tick();
      check("a_b1_data", a_tdata, 64'h0045000801000000);
      tick();
      check("a_ip_len", 64'(be16(a_tdata, 0)), 64'h002E);
      check("a_ident0", 64'(be16(a_tdata, 2)), 64'h0000);
      tick();
      check("a_csum0", 64'(be16(a_tdata, 0)), 64'hB837);
      tick();
      check("a_udp_len", 64'(be16(a_tdata, 6)), 64'h001A);
      repeat (3) tick();
      check("a_last_data", a_tdata, 64'h0000000011100F0E);
      check("a_last_keep", 64'(a_tkeep), 64'h0F);
      check("a_last_flag", 64'(a_tlast), 64'h1);
      for (int unsigned f = 0; f < 3; f++) begin
         if (f > 0) wait_until(1, "a_wait_last");
         k = 0;
         tick();
         while (!a_tvalid && k < 40) begin
            k++;
            tick();
         end
         check("a_gap_len", 64'(k), 64'(GAP));
         if (f == 0) begin
            repeat (2) tick();
            check("a_ident1", 64'(be16(a_tdata, 2)), 64'h0001);
            repeat (3) tick();
            check("a_payload1_first", 64'(a_tdata[23:16]), 64'h01);
         end
      end
      repeat (3) tick();
      rst_a = 1'b1;
      tick();
      check("a_midrst_valid", 64'(a_tvalid), 64'h0);
      check("a_midrst_data", a_tdata, 64'h0);
      check("a_midrst_last", 64'(a_tlast), 64'h0);
      check("a_midrst_keep", 64'(a_tkeep), 64'h0);
      repeat ($urandom_range(0, 20)) tick();
      check("a_held_valid", 64'(a_tvalid), 64'h0);
      rst_a = 1'b0;
      first_beat_a("a_restart_latency");
      repeat (2) tick();
      check("a_restart_ident", 64'(be16(a_tdata, 2)), 64'h0000);
      tick();
      check("a_restart_csum", 64'(be16(a_tdata, 0)), 64'hB837);
      for (int unsigned r = 0; r < 6; r++) begin
         repeat ($urandom_range(1, 150)) tick();
         rst_a = 1'b1;
         repeat ($urandom_range(1, 5)) tick();
         rst_a = 1'b0;
      end
      repeat (100) tick();
   endtask

   task automatic drive_b();
      repeat (3) tick();
      rst_b = 1'b0;
      wait_until(2, "b_wait_first");
      repeat (2) tick();
      check("b_ip_len", 64'(be16(b_tdata, 0)), 64'h0032);
      tick();
      check("b_csum0", 64'(be16(b_tdata, 0)), 64'hB833);
      repeat (4) tick();
      check("b_last_flag", 64'(b_tlast), 64'h1);
      check("b_last_keep", 64'(b_tkeep), 64'hFF);
      check("b_last_data", b_tdata, 64'h1514131211100F0E);
      force u_dut_b.frame_cnt = 16'hFFFF;
      tick();
      release u_dut_b.frame_cnt;
      base_b = 16'hFFFE;
      wait_until(2, "b_wait_preload");
      repeat (2) tick();
      check("b_ident_ffff", 64'(be16(b_tdata, 2)), 64'hFFFF);
      wait_until(3, "b_wait_last_ffff");
      wait_until(2, "b_wait_wrap");
      repeat (2) tick();
      check("b_ident_wrap", 64'(be16(b_tdata, 2)), 64'h0000);
      repeat (30) tick();
   endtask

   initial begin
      fork
         drive_a();
         drive_b();
      join
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
